jogo_rodadas_unidade_controle: RTL
==================================

# jogo_rodadas_unidade_controle

Round-based control unit for the memory-sequence game: each round first plays back the stored sequence on the LEDs up to the current round index. It then collects the player's inputs, comparing them one by one. It sits beside the game datapath (address counter E, round counter R, play register, comparator, sequence memory) and drives its counters and registers. It owns one internal cycle timer shared by the LED playback and the per-play timeout.

## Interface
- `MOSTRA_CICLOS`, default 500: cycles each LED stays on, and also the cycles of the following gap with the LED off, during playback.
- `TIMEOUT_CICLOS`, default 5000: cycles allowed in `espera` before a timeout.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; `reset`=0 at a rising edge forces state `inicial`.
- `iniciar`  in  1  level; starts or restarts a game from `inicial` or any final state.
- `jogada`  in  1  one-cycle pulse from the datapath edge detector.
- `igual`  in  1  registered play equals memory word at address E.
- `fimE`  in  1  address counter E equals round counter R.
- `fimR`  in  1  round counter R is at the last round.
- `zeraE`, `contaE`  out  1  clear / increment address counter.
- `zeraR`, `contaR`  out  1  clear / increment round counter.
- `zeraReg`, `registraReg`  out  1  clear / load play register.
- `ligaLed`  out  1  LEDs show memory word at address E.
- `acertou`, `errou`, `pronto`, `db_timeout`  out  1  status.
- `db_estado`  out  4  current state code.

## Operation
- Moore FSM. State codes: inicial 0, preparacao 1, inicia_rodada 2, mostra 3, apaga 4, proximo_mostra 5, espera 6, registra 7, comparacao 8, proxima_jogada 9, proxima_rodada A, reinicia_jogadas B, final_acerto C, final_erro D, final_timeout F.
- Code E is unused. Both E and any illegal code go to inicial on the next edge.
- Transitions:
  - inicial: `iniciar` → preparacao.
  - preparacao → inicia_rodada.
  - inicia_rodada → mostra.
  - mostra: `fim_t` → apaga.
  - apaga: `fim_t` and `fimE` → reinicia_jogadas; `fim_t` and not `fimE` → proximo_mostra.
  - proximo_mostra → mostra.
  - reinicia_jogadas → espera.
  - espera: `fim_t` → final_timeout; else `jogada` → registra. Timeout wins over a same-cycle `jogada`.
  - registra → comparacao.
  - comparacao:
    - not `igual` → final_erro.
    - `igual` and not `fimE` → proxima_jogada.
    - `igual`, `fimE` and `fimR` → final_acerto.
    - `igual`, `fimE` and not `fimR` → proxima_rodada.
  - proxima_jogada → espera.
  - proxima_rodada → inicia_rodada.
  - Final states: `iniciar` → preparacao; otherwise hold.
- Outputs, decoded from the state register only:
  - `zeraR` and `zeraReg` in preparacao.
  - `zeraE` in preparacao, inicia_rodada and reinicia_jogadas.
  - `contaE` in proximo_mostra and proxima_jogada.
  - `contaR` in proxima_rodada.
  - `registraReg` in registra.
  - `ligaLed` in mostra.
  - `acertou` in C; `errou` in D; `db_timeout` in F.
  - `pronto` in C, D and F.
  - `db_estado` equals the state code.
- Timer:
  - Width is ceil(log2(max(MOSTRA_CICLOS, TIMEOUT_CICLOS))).
  - Cleared whenever the next state differs from the current state, and cleared in every state except mostra, apaga and espera.
  - Increments in those three states.
  - `fim_t` = (count == N−1), where N is MOSTRA_CICLOS in mostra/apaga and TIMEOUT_CICLOS in espera.
  - The count never wraps, because the FSM always leaves the state on `fim_t`.

## Timing
- Reset (`reset`=0 at an edge) puts every output at 0, `db_estado` at 0 and the timer at 0. This takes priority over all inputs, including mid-playback and mid-espera.
- mostra and apaga each last exactly MOSTRA_CICLOS cycles.
- espera times out after exactly TIMEOUT_CICLOS cycles with no `jogada`. The timer restarts on every entry to espera, so each play gets a full budget.
- Latency: 3 cycles from `jogada` sampled to the result state (registra, comparacao, result).
- All strobes are high for exactly one cycle per visit, except `ligaLed` and the status outputs.
- Round k (R=k) plays back k+1 LEDs and expects k+1 plays.

## Structure
- Shared package/include holds the 4-bit state code constants, so the datapath, top-level debug (hex display of `db_estado`) and bench all decode states the same way.
- One sub-module, `contador_ciclos`:
  - Parameterised width.
  - Inputs: clear and enable.
  - Outputs: count.
  - The `fim_t` compare against the per-state limit stays in the FSM.

## Test plan
Bench parameters: MOSTRA_CICLOS=4, TIMEOUT_CICLOS=10. The datapath model has 4 rounds.
- Reset then `iniciar`: states go 0→1→2→3. `ligaLed` is high for 4 cycles, then low for 4. With `fimE`=1 the FSM passes through B to 6. `zeraE` pulses in states 1, 2 and B.
- Full game with all plays correct: playback shows 1, 2, 3, 4 LEDs in successive rounds, and `contaR` pulses 3 times. The game ends in C with `acertou`=`pronto`=1. `iniciar` then returns the FSM to 1.
- Wrong play in round 2, second play: comparacao → D with `errou`=`pronto`=1. The FSM holds D until `iniciar`.
- No `jogada` in espera: on the 10th cycle the FSM goes to F with `db_timeout`=`pronto`=1. A `jogada` asserted on cycle 9 instead gives registra, and the next espera gets a fresh 10 cycles.
- `jogada` on the same cycle as `fim_t` in espera: goes to F, not 7.
- `reset`=0 mid-mostra and mid-espera: next edge gives state 0, `ligaLed`=0 and the timer cleared. With `reset`=1 and `iniciar`=0 the FSM stays in 0.

Source files
------------

// File: rtl/jogo_rodadas_unidade_controle_pkg.sv
// State codes and output bundle shared by the control unit, the datapath,
// the hex debug display and the bench.
package jogo_rodadas_unidade_controle_pkg;

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    PREPARACAO       = 4'h1,
    INICIA_RODADA    = 4'h2,
    MOSTRA           = 4'h3,
    APAGA            = 4'h4,
    PROXIMO_MOSTRA   = 4'h5,
    ESPERA           = 4'h6,
    REGISTRA         = 4'h7,
    COMPARACAO       = 4'h8,
    PROXIMA_JOGADA   = 4'h9,
    PROXIMA_RODADA   = 4'hA,
    REINICIA_JOGADAS = 4'hB,
    FINAL_ACERTO     = 4'hC,
    FINAL_ERRO       = 4'hD,
    FINAL_TIMEOUT    = 4'hF
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraR;
    logic contaR;
    logic zeraReg;
    logic registraReg;
    logic ligaLed;
    logic acertou;
    logic errou;
    logic pronto;
    logic db_timeout;
  } saidas_t;

  // Moore decode: every control line is a pure function of the state.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s             = '0;
    s.zeraR       = (e == PREPARACAO);
    s.zeraReg     = (e == PREPARACAO);
    s.zeraE       = (e == PREPARACAO) || (e == INICIA_RODADA) || (e == REINICIA_JOGADAS);
    s.contaE      = (e == PROXIMO_MOSTRA) || (e == PROXIMA_JOGADA);
    s.contaR      = (e == PROXIMA_RODADA);
    s.registraReg = (e == REGISTRA);
    s.ligaLed     = (e == MOSTRA);
    s.acertou     = (e == FINAL_ACERTO);
    s.errou       = (e == FINAL_ERRO);
    s.db_timeout  = (e == FINAL_TIMEOUT);
    s.pronto      = (e == FINAL_ACERTO) || (e == FINAL_ERRO) || (e == FINAL_TIMEOUT);
    return s;
  endfunction

endpackage

// File: rtl/jogo_rodadas_unidade_controle_if.sv
// Control/status bundle between the round control unit and the game datapath.
interface jogo_rodadas_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimE;
  logic       fimR;
  logic       zeraE;
  logic       contaE;
  logic       zeraR;
  logic       contaR;
  logic       zeraReg;
  logic       registraReg;
  logic       ligaLed;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fimE, fimR,
    output zeraE, contaE, zeraR, contaR, zeraReg, registraReg, ligaLed,
           acertou, errou, pronto, db_timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fimE, fimR,
    input  zeraE, contaE, zeraR, contaR, zeraReg, registraReg, ligaLed,
           acertou, errou, pronto, db_timeout, db_estado
  );
endinterface

// File: rtl/jogo_rodadas_unidade_controle_contador_ciclos.sv
// Free-running cycle counter with synchronous clear (priority) and enable.
module contador_ciclos #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] contagem
);

  always_ff @(posedge clock) begin
    if (zera)
      contagem <= '0;
    else if (conta)
      contagem <= contagem + W'(1);
  end

endmodule

// File: rtl/jogo_rodadas_unidade_controle.sv
// Round control unit of the memory-sequence game: LED playback of the stored
// sequence, then collection and checking of the player's plays.
module jogo_rodadas_unidade_controle
  import jogo_rodadas_unidade_controle_pkg::*;
#(
  parameter int MOSTRA_CICLOS  = 500,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic                           clock,
  input logic                           reset,
  jogo_rodadas_unidade_controle_if.master ctrl
);

  localparam int MAX_CICLOS = (MOSTRA_CICLOS > TIMEOUT_CICLOS) ? MOSTRA_CICLOS : TIMEOUT_CICLOS;
  localparam int TW         = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;
  localparam logic [TW-1:0] LIM_MOSTRA  = TW'(MOSTRA_CICLOS - 1);
  localparam logic [TW-1:0] LIM_TIMEOUT = TW'(TIMEOUT_CICLOS - 1);

  estado_t       estado;
  estado_t       prox;
  saidas_t       saidas;
  logic [TW-1:0] contagem;
  logic          temporizado;
  logic          fim_t;
  logic          zera_t;

  always_comb begin
    temporizado = (estado == MOSTRA) || (estado == APAGA) || (estado == ESPERA);
    fim_t       = 1'b0;
    if (estado == ESPERA)
      fim_t = (contagem == LIM_TIMEOUT);
    else if ((estado == MOSTRA) || (estado == APAGA))
      fim_t = (contagem == LIM_MOSTRA);
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:          if (ctrl.iniciar) prox = PREPARACAO;
      PREPARACAO:       prox = INICIA_RODADA;
      INICIA_RODADA:    prox = MOSTRA;
      MOSTRA:           if (fim_t) prox = APAGA;
      APAGA:            if (fim_t) prox = ctrl.fimE ? REINICIA_JOGADAS : PROXIMO_MOSTRA;
      PROXIMO_MOSTRA:   prox = MOSTRA;
      REINICIA_JOGADAS: prox = ESPERA;
      // Timeout wins over a play arriving on the same cycle.
      ESPERA: begin
        if (fim_t)             prox = FINAL_TIMEOUT;
        else if (ctrl.jogada)  prox = REGISTRA;
      end
      REGISTRA:         prox = COMPARACAO;
      COMPARACAO: begin
        if (!ctrl.igual)      prox = FINAL_ERRO;
        else if (!ctrl.fimE)  prox = PROXIMA_JOGADA;
        else if (ctrl.fimR)   prox = FINAL_ACERTO;
        else                  prox = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA:   prox = ESPERA;
      PROXIMA_RODADA:   prox = INICIA_RODADA;
      FINAL_ACERTO,
      FINAL_ERRO,
      FINAL_TIMEOUT:    if (ctrl.iniciar) prox = PREPARACAO;
      default:          prox = INICIAL;
    endcase
  end

  // Timer restarts on every state change, so each visit gets a full budget.
  assign zera_t = !reset || (prox != estado) || !temporizado;

  contador_ciclos #(.W(TW)) u_contador (
    .clock    (clock),
    .zera     (zera_t),
    .conta    (temporizado),
    .contagem (contagem)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= prox;
      saidas <= decodifica(prox);
    end
  end

  assign ctrl.zeraE       = saidas.zeraE;
  assign ctrl.contaE      = saidas.contaE;
  assign ctrl.zeraR       = saidas.zeraR;
  assign ctrl.contaR      = saidas.contaR;
  assign ctrl.zeraReg     = saidas.zeraReg;
  assign ctrl.registraReg = saidas.registraReg;
  assign ctrl.ligaLed     = saidas.ligaLed;
  assign ctrl.acertou     = saidas.acertou;
  assign ctrl.errou       = saidas.errou;
  assign ctrl.pronto      = saidas.pronto;
  assign ctrl.db_timeout  = saidas.db_timeout;
  assign ctrl.db_estado   = estado;

endmodule
